// File: rtl/decode_ctrl_pkg.sv
// Shared types and constants for the decode issue controller and the decoder.
package decode_ctrl_pkg;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    VALID = 2'd1,
    FLUSH = 2'd2
  } ctrl_state_e;

  // All-zero word is what the decoder sees when no real instruction is present.
  localparam logic [31:0] NOP_INSTR = 32'h0000_0000;

  // Major opcodes shared with the decoder.
  localparam logic [6:0] OPC_LOAD   = 7'b000_0011;
  localparam logic [6:0] OPC_OP_IMM = 7'b001_0011;
  localparam logic [6:0] OPC_STORE  = 7'b010_0011;
  localparam logic [6:0] OPC_OP     = 7'b011_0011;
  localparam logic [6:0] OPC_BRANCH = 7'b110_0011;
  localparam logic [6:0] OPC_JAL    = 7'b110_1111;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } fetch_pkt_t;

  function automatic logic [6:0] opcode_of(input logic [31:0] instr);
    return instr[6:0];
  endfunction

endpackage

// File: rtl/decode_issue_ctrl_if.sv
// Fetch-side, stall/flush and decode-side signals of the issue controller.
interface decode_issue_ctrl_if;
  logic        fetch_valid;
  logic [31:0] fetch_instr;
  logic [31:0] fetch_pc;
  logic        fetch_ready;
  logic        stall;
  logic        flush;
  logic [31:0] dec_instr;
  logic        dec_valid;
  logic [31:0] dec_pc;
  logic        out_valid;
  logic [31:0] out_pc;
  logic [31:0] issue_count;

  modport master (
    output fetch_valid, fetch_instr, fetch_pc, stall, flush,
    input  fetch_ready, dec_instr, dec_valid, dec_pc, out_valid, out_pc, issue_count
  );

  modport slave (
    input  fetch_valid, fetch_instr, fetch_pc, stall, flush,
    output fetch_ready, dec_instr, dec_valid, dec_pc, out_valid, out_pc, issue_count
  );
endinterface

// File: rtl/decode_issue_ctrl_instr_fifo.sv
// Small {pc, instr} FIFO; flush empties it and drops any same-cycle push.
module instr_fifo
  import decode_ctrl_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   flush,
  input  logic                   push,
  input  fetch_pkt_t             push_data,
  input  logic                   pop,
  output fetch_pkt_t             head_data,
  output logic [$clog2(DEPTH):0] count,
  output logic                   empty
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  fetch_pkt_t         mem_r [DEPTH];
  logic [PTR_W-1:0]   wr_ptr_r;
  logic [PTR_W-1:0]   rd_ptr_r;
  logic [CNT_W-1:0]   count_r;
  logic               full_s;
  logic               push_ok_s;
  logic               pop_ok_s;

  assign full_s    = (count_r == CNT_W'(DEPTH));
  assign empty     = (count_r == CNT_W'(0));
  assign push_ok_s = push && !full_s && !flush;
  assign pop_ok_s  = pop && !empty && !flush;
  assign head_data = mem_r[rd_ptr_r];
  assign count     = count_r;

  // Storage write; entries need no reset since count guards every read.
  always_ff @(posedge clk) begin
    if (push_ok_s) begin
      mem_r[wr_ptr_r] <= push_data;
    end
  end

  // Pointers wrap naturally at DEPTH (power of two); flush empties the queue.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_r <= PTR_W'(0);
      rd_ptr_r <= PTR_W'(0);
      count_r  <= CNT_W'(0);
    end else if (flush) begin
      wr_ptr_r <= PTR_W'(0);
      rd_ptr_r <= PTR_W'(0);
      count_r  <= CNT_W'(0);
    end else begin
      if (push_ok_s) wr_ptr_r <= wr_ptr_r + PTR_W'(1);
      if (pop_ok_s)  rd_ptr_r <= rd_ptr_r + PTR_W'(1);
      case ({push_ok_s, pop_ok_s})
        2'b10:   count_r <= count_r + CNT_W'(1);
        2'b01:   count_r <= count_r - CNT_W'(1);
        default: count_r <= count_r;
      endcase
    end
  end

endmodule

// File: rtl/decode_issue_ctrl.sv
// Feeds one buffered instruction per cycle into the decoder slot and tracks
// which slots were actually consumed, aligned with the decoder's output stage.
module decode_issue_ctrl
  import decode_ctrl_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                clk,
  input  logic                reset,
  decode_issue_ctrl_if.slave  bus
);

  localparam int CNT_W = $clog2(DEPTH) + 1;

  ctrl_state_e        state_r;
  ctrl_state_e        state_nxt_s;
  fetch_pkt_t         push_pkt_s;
  fetch_pkt_t         head_s;
  logic [CNT_W-1:0]   fifo_count_s;
  logic               fifo_empty_s;
  logic               fetch_ready_s;
  logic               push_s;
  logic               pop_s;
  logic               consume_s;
  logic [31:0]        dec_instr_r;
  logic [31:0]        dec_instr_nxt_s;
  logic [31:0]        dec_pc_r;
  logic [31:0]        dec_pc_nxt_s;
  logic               dec_valid_r;
  logic               dec_valid_nxt_s;
  logic               out_valid_r;
  logic [31:0]        out_pc_r;
  logic [31:0]        issue_count_r;

  // Ready depends only on registered state so fetch never sees a comb loop.
  assign fetch_ready_s  = (fifo_count_s < CNT_W'(DEPTH)) && (state_r != FLUSH);
  assign push_s         = bus.fetch_valid && fetch_ready_s;
  assign push_pkt_s.pc    = bus.fetch_pc;
  assign push_pkt_s.instr = bus.fetch_instr;
  assign consume_s      = dec_valid_r && !bus.stall && !bus.flush;

  instr_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .flush     (bus.flush),
    .push      (push_s),
    .push_data (push_pkt_s),
    .pop       (pop_s),
    .head_data (head_s),
    .count     (fifo_count_s),
    .empty     (fifo_empty_s)
  );

  // Next-state and slot contents; flush overrides every state.
  always_comb begin
    state_nxt_s     = state_r;
    pop_s           = 1'b0;
    dec_instr_nxt_s = dec_instr_r;
    dec_pc_nxt_s    = dec_pc_r;
    dec_valid_nxt_s = dec_valid_r;
    if (bus.flush) begin
      state_nxt_s     = FLUSH;
      dec_instr_nxt_s = NOP_INSTR;
      dec_pc_nxt_s    = 32'h0000_0000;
      dec_valid_nxt_s = 1'b0;
    end else begin
      case (state_r)
        EMPTY: begin
          if (!fifo_empty_s) begin
            pop_s           = 1'b1;
            state_nxt_s     = VALID;
            dec_instr_nxt_s = head_s.instr;
            dec_pc_nxt_s    = head_s.pc;
            dec_valid_nxt_s = 1'b1;
          end else begin
            dec_instr_nxt_s = NOP_INSTR;
            dec_pc_nxt_s    = 32'h0000_0000;
            dec_valid_nxt_s = 1'b0;
          end
        end
        VALID: begin
          if (bus.stall) begin
            state_nxt_s = VALID;
          end else if (!fifo_empty_s) begin
            pop_s           = 1'b1;
            dec_instr_nxt_s = head_s.instr;
            dec_pc_nxt_s    = head_s.pc;
            dec_valid_nxt_s = 1'b1;
          end else begin
            state_nxt_s     = EMPTY;
            dec_instr_nxt_s = NOP_INSTR;
            dec_pc_nxt_s    = 32'h0000_0000;
            dec_valid_nxt_s = 1'b0;
          end
        end
        FLUSH: begin
          state_nxt_s     = EMPTY;
          dec_instr_nxt_s = NOP_INSTR;
          dec_pc_nxt_s    = 32'h0000_0000;
          dec_valid_nxt_s = 1'b0;
        end
        default: begin
          state_nxt_s     = EMPTY;
          dec_instr_nxt_s = NOP_INSTR;
          dec_pc_nxt_s    = 32'h0000_0000;
          dec_valid_nxt_s = 1'b0;
        end
      endcase
    end
  end

  // State and decoder slot registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r     <= EMPTY;
      dec_instr_r <= NOP_INSTR;
      dec_pc_r    <= 32'h0000_0000;
      dec_valid_r <= 1'b0;
    end else begin
      state_r     <= state_nxt_s;
      dec_instr_r <= dec_instr_nxt_s;
      dec_pc_r    <= dec_pc_nxt_s;
      dec_valid_r <= dec_valid_nxt_s;
    end
  end

  // One out_valid pulse per consumed slot, lined up with the decoder's output register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_valid_r   <= 1'b0;
      out_pc_r      <= 32'h0000_0000;
      issue_count_r <= 32'h0000_0000;
    end else begin
      out_valid_r <= consume_s;
      if (consume_s) begin
        out_pc_r      <= dec_pc_r;
        issue_count_r <= issue_count_r + 32'd1;
      end
    end
  end

  assign bus.fetch_ready = fetch_ready_s;
  assign bus.dec_instr   = dec_instr_r;
  assign bus.dec_valid   = dec_valid_r;
  assign bus.dec_pc      = dec_pc_r;
  assign bus.out_valid   = out_valid_r;
  assign bus.out_pc      = out_pc_r;
  assign bus.issue_count = issue_count_r;

endmodule

// File: tb/tb_decode_issue_ctrl.sv
// Scoreboard bench for decode_issue_ctrl: directed pushes queue the expected
// {pc, instr} of every instruction that must issue; a monitor pops on consume.
module tb_decode_issue_ctrl;
  import decode_ctrl_pkg::*;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  decode_issue_ctrl_if bus();

  decode_issue_ctrl #(.DEPTH(4)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int          n_vec = 0;
  int          n_fail = 0;
  logic [63:0] exp_q[$];
  logic        pend = 1'b0;
  logic [31:0] pend_pc = 32'h0;
  logic [31:0] exp_issue = 32'h0;
  int          run_len = 0;
  int          max_run = 0;
  int          ready_waits = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // addi x1, x0, pc[11:0]
  function automatic logic [31:0] ins(input logic [31:0] pc);
    return {pc[11:0], 20'h00093};
  endfunction

  // Monitor: checks out_valid/out_pc/issue_count for the previous consume,
  // then pops the scoreboard when the slot is consumed this cycle.
  initial begin
    logic [63:0] e;
    forever begin
      @(negedge clk);
      if (reset) begin
        pend      = 1'b0;
        exp_issue = 32'h0;
        run_len   = 0;
      end else begin
        if (pend) begin
          chk("out_valid", 32'(bus.out_valid), 32'd1);
          chk("out_pc", bus.out_pc, pend_pc);
          exp_issue = exp_issue + 32'd1;
          chk("issue_count", bus.issue_count, exp_issue);
        end else begin
          chk("out_valid_idle", 32'(bus.out_valid), 32'd0);
        end
        if (bus.out_valid) run_len++; else run_len = 0;
        if (run_len > max_run) max_run = run_len;
        pend = 1'b0;
        if (bus.dec_valid && !bus.stall && !bus.flush) begin
          if (exp_q.size() == 0) begin
            n_vec++;
            n_fail++;
            $display("FAIL unexpected_issue: got pc %h expected no issue", bus.dec_pc);
          end else begin
            e = exp_q.pop_front();
            chk("dec_pc", bus.dec_pc, e[63:32]);
            chk("dec_instr", bus.dec_instr, e[31:0]);
            pend    = 1'b1;
            pend_pc = e[63:32];
          end
        end
      end
    end
  end

  // Offer one instruction; waits (bounded) for fetch_ready. Returns 1ns after the accept edge.
  task automatic push_item(input logic [31:0] pc, input logic [31:0] instr, input bit will_issue);
    int w = 0;
    bus.fetch_valid = 1'b1;
    bus.fetch_pc    = pc;
    bus.fetch_instr = instr;
    @(negedge clk);
    while (!bus.fetch_ready && w < 100) begin
      w++;
      ready_waits++;
      @(negedge clk);
    end
    if (!bus.fetch_ready) begin
      chk("push_timeout", 32'(bus.fetch_ready), 32'd1);
      bus.fetch_valid = 1'b0;
    end else begin
      if (will_issue) exp_q.push_back({pc, instr});
      @(posedge clk);
      #1;
      bus.fetch_valid = 1'b0;
    end
  endtask

  // Wait (bounded) until every expected instruction has issued and been checked.
  task automatic drain();
    int w = 0;
    while ((exp_q.size() != 0 || pend) && w < 200) begin
      @(negedge clk);
      w++;
    end
    @(negedge clk);
    chk("drain_left", 32'(exp_q.size()), 32'd0);
    @(posedge clk);
    #1;
  endtask

  // Push into an empty controller and check the slot timing around it.
  task automatic latency_check(input string tag, input logic [31:0] pc, input logic [31:0] instr,
                               input logic [31:0] cnt_after);
    push_item(pc, instr, 1'b1);
    @(negedge clk);
    chk({tag, "_not_yet"}, 32'(bus.dec_valid), 32'd0);
    @(negedge clk);
    chk({tag, "_dec_valid"}, 32'(bus.dec_valid), 32'd1);
    chk({tag, "_dec_instr"}, bus.dec_instr, instr);
    @(negedge clk);
    chk({tag, "_out_pc"}, bus.out_pc, pc);
    chk({tag, "_cnt"}, bus.issue_count, cnt_after);
    chk({tag, "_nop_back"}, bus.dec_instr, 32'h0);
    chk({tag, "_valid_back"}, 32'(bus.dec_valid), 32'd0);
    @(posedge clk);
    #1;
  endtask

  initial begin
    bus.fetch_valid = 1'b0;
    bus.fetch_pc    = 32'h0;
    bus.fetch_instr = 32'h0;
    bus.stall       = 1'b0;
    bus.flush       = 1'b0;
    reset           = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;

    // Reset state
    @(negedge clk);
    chk("rst_dec_instr", bus.dec_instr, 32'h0);
    chk("rst_dec_valid", 32'(bus.dec_valid), 32'd0);
    chk("rst_dec_pc", bus.dec_pc, 32'h0);
    chk("rst_out_pc", bus.out_pc, 32'h0);
    chk("rst_issue_count", bus.issue_count, 32'h0);
    chk("rst_fetch_ready", 32'(bus.fetch_ready), 32'd1);
    @(posedge clk);
    #1;

    // Single instruction latency
    latency_check("t1", 32'h0, 32'h0050_0093, 32'd1);
    drain();

    // 8 back-to-back, no stall
    ready_waits = 0;
    for (int i = 0; i < 8; i++) push_item(32'(i * 4), ins(32'(i * 4)), 1'b1);
    drain();
    chk("t2_ready_waits", 32'(ready_waits), 32'd0);
    chk("t2_run_ge_8", 32'(max_run >= 8), 32'd1);
    chk("t2_issue_count", bus.issue_count, 32'd9);

    // Stall three cycles on pc 0x4
    for (int i = 0; i < 3; i++) push_item(32'(i * 4), ins(32'(i * 4)), 1'b1);
    begin
      int w = 0;
      while (!(bus.dec_valid && bus.dec_pc == 32'h4) && w < 20) begin
        @(posedge clk);
        #1;
        w++;
      end
    end
    bus.stall = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("t3_stall_pc", bus.dec_pc, 32'h4);
      chk("t3_stall_instr", bus.dec_instr, 32'h0040_0093);
      @(posedge clk);
      #1;
    end
    bus.stall = 1'b0;
    @(negedge clk);
    chk("t3_last_pc", bus.dec_pc, 32'h4);
    @(posedge clk);
    #1;
    drain();
    chk("t3_issue_count", bus.issue_count, 32'd12);

    // Stall while 6 pushes are offered: FIFO fills, sixth waits
    bus.stall = 1'b1;
    fork
      begin
        for (int i = 0; i < 6; i++) push_item(32'h100 + 32'(i * 4), ins(32'h100 + 32'(i * 4)), 1'b1);
      end
      begin
        int w = 0;
        @(negedge clk);
        while (bus.fetch_ready && w < 50) begin
          @(negedge clk);
          w++;
        end
        chk("t4_full_ready", 32'(bus.fetch_ready), 32'd0);
        chk("t4_slot_pc", bus.dec_pc, 32'h100);
        chk("t4_slot_valid", 32'(bus.dec_valid), 32'd1);
        repeat (3) @(posedge clk);
        #1;
        bus.stall = 1'b0;
      end
    join
    drain();
    chk("t4_issue_count", bus.issue_count, 32'd18);

    // Flush with 3 queued plus a same-cycle push
    bus.stall = 1'b1;
    for (int i = 0; i < 4; i++) push_item(32'h200 + 32'(i * 4), ins(32'h200 + 32'(i * 4)), 1'b0);
    bus.flush       = 1'b1;
    bus.fetch_valid = 1'b1;
    bus.fetch_pc    = 32'h300;
    bus.fetch_instr = ins(32'h300);
    @(posedge clk);
    #1;
    bus.flush       = 1'b0;
    bus.fetch_valid = 1'b0;
    bus.stall       = 1'b0;
    @(negedge clk);
    chk("t5_dec_valid", 32'(bus.dec_valid), 32'd0);
    chk("t5_dec_instr", bus.dec_instr, 32'h0);
    chk("t5_ready_low", 32'(bus.fetch_ready), 32'd0);
    chk("t5_out_valid", 32'(bus.out_valid), 32'd0);
    @(negedge clk);
    chk("t5_ready_back", 32'(bus.fetch_ready), 32'd1);
    repeat (4) @(posedge clk);
    #1;
    chk("t5_issue_count", bus.issue_count, 32'd18);
    push_item(32'h400, ins(32'h400), 1'b1);
    drain();
    chk("t5_after_count", bus.issue_count, 32'd19);

    // Asynchronous reset mid-stream with 2 queued
    bus.stall = 1'b1;
    for (int i = 0; i < 3; i++) push_item(32'h500 + 32'(i * 4), ins(32'h500 + 32'(i * 4)), 1'b0);
    #2;
    reset = 1'b1;
    #1;
    chk("t6_dec_instr", bus.dec_instr, 32'h0);
    chk("t6_dec_valid", 32'(bus.dec_valid), 32'd0);
    chk("t6_dec_pc", bus.dec_pc, 32'h0);
    chk("t6_out_valid", 32'(bus.out_valid), 32'd0);
    chk("t6_out_pc", bus.out_pc, 32'h0);
    chk("t6_issue_count", bus.issue_count, 32'h0);
    bus.stall = 1'b0;
    @(negedge clk);
    @(posedge clk);
    #1;
    reset = 1'b0;
    @(posedge clk);
    #1;
    latency_check("t6", 32'h600, ins(32'h600), 32'd1);
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
